// File: rtl/result_streamer_pkg.sv
// result_streamer_pkg
// Shared definitions for the result streamer: FSM state encoding, the
// BRAM word size in bytes, and the width of the word counters.
package result_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Byte stride between consecutive result words in the BRAM.
    localparam int WORD_BYTES = 4;

    // Wide enough to hold any packet length from 0 up to 1024 words.
    localparam int CNT_W = 11;

endpackage

// File: rtl/result_streamer_fifo.sv
// stream_fifo2
// Two-entry synchronous FIFO with registered outputs. The head word sits in
// its own register, so o_data comes straight from a flop. Push and pop in
// the same cycle are legal at any occupancy, including when full.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset (clears data too)
//   i_clear      empties the FIFO (stored data left as is)
//   i_push       write i_data this cycle
//   i_data       write data
//   i_pop        consume the head word (ignored when empty)
//   o_data       head word
//   o_valid      FIFO holds at least one word
//   o_count      occupancy, 0..2
module stream_fifo2 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic [1:0]        r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else if (i_clear) begin
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (i_push) begin
                        r_head  <= i_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({i_push, i_pop})
                        2'b10: begin
                            r_tail  <= i_data;
                            r_count <= 2'd2;
                        end
                        2'b01: r_count <= 2'd0;
                        // Head leaves and the new word takes its place.
                        2'b11: r_head <= i_data;
                        default: ;
                    endcase
                end
                default: begin
                    // Full: a pop promotes the tail; a simultaneous push
                    // refills the tail slot in the same cycle.
                    case ({i_push, i_pop})
                        2'b01: begin
                            r_head  <= r_tail;
                            r_count <= 2'd1;
                        end
                        2'b11: begin
                            r_head <= r_tail;
                            r_tail <= i_data;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    assign o_data  = r_head;
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/result_streamer.sv
// result_streamer
// Once the gate stage raises start, reads N_WORDS result words from the MAC
// result BRAM and sends them out as a single AXI4-Stream packet. Words pass
// through untouched. Reads are credit-limited so that buffered plus
// in-flight words never exceed the two-entry output buffer. done reports
// completion and is held until start is released.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   start        level request from the gate stage
//   done         packet fully accepted; held until start falls
//   busy         packet in progress (RUN or FLUSH)
//   rd_en        BRAM read strobe
//   rd_addr      BRAM byte address (meaningful when rd_en=1)
//   rd_data      BRAM read data, valid one cycle after rd_en
//   m_tdata      stream data
//   m_tvalid     stream valid
//   m_tready     stream ready
//   m_tlast      final word of the packet
//   dbg_state    current FSM state
//
// Stream handshake: a word transfers on every cycle where m_tvalid and
// m_tready are both high. Once m_tvalid rises it stays high, with m_tdata
// unchanged, until that transfer happens; only reset may drop it early.
module result_streamer
    import result_streamer_pkg::*;
#(
    parameter int N_WORDS   = 6,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output state_t            dbg_state
);

    localparam logic [CNT_W-1:0]  LP_N    = CNT_W'(N_WORDS);
    localparam logic [CNT_W-1:0]  LP_LAST = CNT_W'(N_WORDS - 1);
    localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_accepted;
    logic              r_inflight;

    logic              w_rd_en;
    logic              w_pop;
    logic              w_clear;
    logic [1:0]        w_occ;
    logic              w_fifo_valid;
    logic [DATA_W-1:0] w_fifo_data;
    logic [2:0]        w_level;
    logic              w_last;

    stream_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_push  (r_inflight),
        .i_data  (rd_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_valid (w_fifo_valid),
        .o_count (w_occ)
    );

    assign w_pop   = w_fifo_valid & m_tready;
    assign w_clear = (r_state == IDLE);
    assign w_last  = w_fifo_valid & (r_accepted == LP_LAST);

    // Words already committed to the buffer: stored plus the one whose read
    // data lands this cycle.
    assign w_level = {1'b0, w_occ} + {2'b00, r_inflight};

    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                // Read only if the word fits once this cycle's pop (if any)
                // frees a slot: level - pop < 2, written without subtraction.
                if ((r_issued < LP_N) && (w_level < (3'd2 + {2'b00, w_pop}))) begin
                    w_rd_en = 1'b1;
                end
                if (w_rd_en && (r_issued == LP_LAST)) begin
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (w_pop && w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (!start) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_issued   <= '0;
            r_accepted <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_rd_en;
            if (w_clear) begin
                r_issued   <= '0;
                r_accepted <= '0;
            end else begin
                if (w_rd_en) begin
                    r_issued <= r_issued + CNT_W'(1);
                end
                if (w_pop) begin
                    r_accepted <= r_accepted + CNT_W'(1);
                end
            end
        end
    end

    assign done      = (r_state == DONE);
    assign busy      = (r_state == RUN) || (r_state == FLUSH);
    assign rd_en     = w_rd_en;
    assign rd_addr   = LP_BASE + ADDR_W'(r_issued) * ADDR_W'(WORD_BYTES);
    assign m_tdata   = w_fifo_data;
    assign m_tvalid  = w_fifo_valid;
    assign m_tlast   = w_last;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_result_streamer.sv
module tb_result_streamer;
    import result_streamer_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int N6    = 6;
    localparam int BASE6 = 0;
    localparam int BASE1 = 'h40;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // ---------------- DUT (N_WORDS=6, BASE_ADDR=0) ----------------
    logic          start, done, busy, rd_en, m_tvalid, m_tready, m_tlast;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data, m_tdata;
    state_t        dbg_state;

    result_streamer #(.N_WORDS(N6), .BASE_ADDR(BASE6), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .dbg_state(dbg_state)
    );

    // ---------------- DUT (N_WORDS=1, BASE_ADDR=0x40) ----------------
    logic          start1, done1, busy1, rd_en1, m_tvalid1, m_tready1, m_tlast1;
    logic [AW-1:0] rd_addr1;
    logic [DW-1:0] rd_data1, m_tdata1;
    state_t        dbg_state1;

    result_streamer #(.N_WORDS(1), .BASE_ADDR(BASE1), .ADDR_W(AW), .DATA_W(DW)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .done(done1), .busy(busy1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .m_tdata(m_tdata1), .m_tvalid(m_tvalid1), .m_tready(m_tready1),
        .m_tlast(m_tlast1), .dbg_state(dbg_state1)
    );

    // ---------------- BRAM models: 1-cycle read latency ----------------
    logic [DW-1:0] mem6 [1024];
    logic [DW-1:0] mem1 [1024];
    always @(posedge clk) if (rd_en)  rd_data  <= mem6[rd_addr[AW-1:2]];
    always @(posedge clk) if (rd_en1) rd_data1 <= mem1[rd_addr1[AW-1:2]];

    // ---------------- scoreboard state ----------------
    int            total, bad;
    int            cyc, t_start, n_reads, n_beats;
    logic [DW-1:0] exp_q [$];
    logic          mon_on, prev_stall;
    logic [DW-1:0] prev_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the packet is the list of words at BASE6/4 + i; every
    // handshake must take the next one, and reads issued minus words
    // accepted may never exceed the two-word buffer.
    task automatic monitor();
        if (!mon_on) return;
        if (prev_stall) begin
            check("hold_valid", m_tvalid, 1);
            check("hold_data", m_tdata, prev_data);
        end
        if (rd_en) begin
            n_reads++;
            check("rd_addr", rd_addr, 64'(BASE6 + 4 * (n_reads - 1)));
            check("credit", (n_reads - n_beats - ((m_tvalid && m_tready) ? 1 : 0)) <= 2, 1);
        end
        if (m_tvalid && m_tready) begin
            check("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                check("beat_data", m_tdata, exp_q[0]);
                check("beat_last", m_tlast, exp_q.size() == 1);
                void'(exp_q.pop_front());
            end
            n_beats++;
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; outputs are checked
    // on the falling edge.
    task automatic step(input logic rdy);
        @(posedge clk);
        #1;
        cyc++;
        m_tready = rdy;
        @(negedge clk);
        monitor();
    endtask

    task automatic begin_packet();
        exp_q.delete();
        for (int i = 0; i < N6; i++) exp_q.push_back(mem6[BASE6 / 4 + i]);
        n_reads    = 0;
        n_beats    = 0;
        prev_stall = 1'b0;
        mon_on     = 1'b1;
        start      = 1'b1;
        t_start    = cyc;
    endtask

    task automatic run_until_done(input int pct, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            step($urandom_range(0, 99) < pct);
            k++;
        end
        check("done_reached", done, 1);
    endtask

    task automatic end_packet(input string tag);
        check({tag, "_beats"}, n_beats, N6);
        check({tag, "_reads"}, n_reads, N6);
        check({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    task automatic chk_reset6(input string tag);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, BASE6);
        check({tag, "_tvalid"}, m_tvalid, 0);
        check({tag, "_tdata"}, m_tdata, 0);
        check({tag, "_tlast"}, m_tlast, 0);
        check({tag, "_state"}, dbg_state, IDLE);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        total = 0; bad = 0; cyc = 0; t_start = 0;
        n_reads = 0; n_beats = 0; mon_on = 1'b0; prev_stall = 1'b0; prev_data = '0;
        for (int i = 0; i < 1024; i++) begin
            mem6[i] = '0;
            mem1[i] = '0;
        end
        for (int i = 0; i < N6; i++) mem6[i] = 32'h3F80_0000 + 32'(i);
        mem1[BASE1 / 4] = $urandom;

        reset = 1'b1; start = 1'b0; start1 = 1'b0; m_tready = 1'b0; m_tready1 = 1'b1;
        step(0);
        step(0);
        chk_reset6("rst");
        check("rst1_tvalid", m_tvalid1, 0);
        check("rst1_rd_addr", rd_addr1, BASE1);
        check("rst1_done", done1, 0);
        reset = 1'b0;
        step(1);

        // A: full-rate packet, cycle-exact timing
        begin_packet();
        for (int r = 1; r <= 10; r++) begin
            step(1);
            check("A_valid", m_tvalid, (r >= 3 && r <= 8));
            check("A_last", m_tlast, r == 8);
            check("A_rd_en", rd_en, (r >= 1 && r <= 6));
            check("A_done", done, r >= 9);
            check("A_busy", busy, (r >= 1 && r <= 8));
            if (r >= 3 && r <= 8) check("A_data", m_tdata, 32'h3F80_0000 + 32'(r - 3));
        end
        check("A_state", dbg_state, DONE);
        end_packet("A");
        start = 1'b0;
        step(1);
        check("A_done_fall", done, 0);
        check("A_idle", dbg_state, IDLE);

        // B: random backpressure (~30% ready), random data
        for (int i = 0; i < N6; i++) mem6[i] = $urandom;
        begin_packet();
        run_until_done(30, 400);
        end_packet("B");
        start = 1'b0;
        step(1);

        // C: ready low for 20 cycles from cycle 3
        for (int i = 0; i < N6; i++) mem6[i] = 32'h3F80_0000 + 32'(i);
        begin_packet();
        step(1);
        step(1);
        for (int r = 3; r <= 22; r++) step(0);
        check("C_reads_stalled", n_reads, 2);
        check("C_valid_stalled", m_tvalid, 1);
        check("C_data_stalled", m_tdata, mem6[0]);
        for (int r = 23; r <= 28; r++) begin
            step(1);
            check("C_stream_valid", m_tvalid, 1);
            check("C_stream_beats", n_beats, r - 22);
        end
        check("C_last", m_tlast, 1);
        step(1);
        check("C_done", done, 1);
        end_packet("C");

        // D: start held high after done -> no new packet
        for (int r = 0; r < 10; r++) begin
            step(1);
            check("D_done_held", done, 1);
            check("D_no_read", rd_en, 0);
        end
        check("D_reads", n_reads, N6);
        start = 1'b0;
        step(1);
        check("D_done_fall", done, 0);

        // E: second packet from BASE_ADDR, reset while word 3 is stalled
        begin_packet();
        step(1);
        check("E_first_addr", rd_addr, BASE6);
        check("E_first_rd", rd_en, 1);
        for (int r = 2; r <= 5; r++) step(1);
        for (int r = 6; r <= 8; r++) step(0);
        check("E_stall_beats", n_beats, 3);
        check("E_stall_valid", m_tvalid, 1);
        check("E_stall_data", m_tdata, mem6[3]);
        mon_on = 1'b0;
        reset  = 1'b1;
        start  = 1'b0;
        step(0);
        chk_reset6("E_rst");
        reset = 1'b0;
        step(1);
        begin_packet();
        run_until_done(100, 40);
        end_packet("E_fresh");
        start = 1'b0;
        step(1);
        mon_on = 1'b0;

        // F: N_WORDS=1, BASE_ADDR=0x40
        start1  = 1'b1;
        t_start = cyc;
        for (int r = 1; r <= 4; r++) begin
            step(1);
            check("F_rd_en", rd_en1, r == 1);
            if (r == 1) check("F_rd_addr", rd_addr1, BASE1);
            check("F_valid", m_tvalid1, r == 3);
            check("F_last", m_tlast1, r == 3);
            if (r == 3) check("F_data", m_tdata1, mem1[BASE1 / 4]);
            check("F_done", done1, r == 4);
        end
        start1 = 1'b0;
        step(1);
        check("F_done_fall", done1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_streamer.md
# result_streamer

Drains the MAC result BRAM after the gate stage finishes and streams its contents to the PS-side DMA as an AXI4-Stream packet. Sits directly downstream of the 8-MAC gate stage: its `start` is that stage's `pl_status[0]`, and it reads the same result BRAM on a second port. Handles the 1-cycle BRAM read latency and arbitrary `m_tready` backpressure with a 2-entry output buffer, and reports completion to the PS.

## Interface
- `N_WORDS`, 6, words per packet; legal range 1..1024
- `BASE_ADDR`, 0, byte address of first word; must be a multiple of 4
- `ADDR_W`, 12, BRAM byte-address width
- `DATA_W`, 32, word width (fp32 MAC results, passed through untouched)

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  level request; from gate stage `pl_status[0]`
- `done`  out  1  packet fully accepted; held until `start` falls
- `busy`  out  1  high in RUN or FLUSH
- `rd_en`  out  1  BRAM read strobe
- `rd_addr`  out  ADDR_W  BRAM byte address; meaningful only when `rd_en`=1
- `rd_data`  in  DATA_W  BRAM read data, valid exactly 1 cycle after `rd_en`
- `m_tdata`  out  DATA_W  stream data
- `m_tvalid`  out  1  stream valid
- `m_tready`  in  1  stream ready
- `m_tlast`  out  1  high on the final word of the packet

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE: issue counter, accept counter and buffer cleared. `start`=1 moves to RUN.
- RUN: assert `rd_en` when `issued < N_WORDS` and `occupancy + inflight - pop < 2`, where `pop` = `m_tvalid & m_tready` in the current cycle. `rd_addr = BASE_ADDR + 4*issued`, and `issued` increments on each read. Move to FLUSH in the cycle after the read that makes `issued` equal `N_WORDS`.
- `rd_data` is written into the buffer on the cycle after each `rd_en`, unconditionally. The credit rule guarantees no overflow.
- Buffer output drives `m_tdata`/`m_tvalid`. `m_tlast`=1 when the head word is word index `N_WORDS-1`. `accepted` increments on each handshake.
- FLUSH: move to DONE on the handshake with `m_tlast`=1.
- DONE: `done`=1. Move to IDLE when `start`=0. `start` still high in DONE means no new packet starts.
- `m_tvalid`, once high, holds and `m_tdata` stays stable until the handshake (AXI-S rule).
- `start` falling in RUN or FLUSH is ignored and the packet completes. Only `reset` aborts.
- Reset mid-packet: all state is cleared at the next edge. `m_tvalid` drops without a handshake, and this is permitted only under reset.
- Data is not modified; bit patterns pass through exactly.

## Timing
- Reset values: `done`=0, `busy`=0, `rd_en`=0, `rd_addr`=`BASE_ADDR`, `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0. FSM is IDLE.
- `start` sampled high at edge 0 gives RUN in cycle 1. First `rd_en` is in cycle 1, and data is valid in cycle 2.
- First `m_tvalid` is in cycle 3, giving 3 cycles of latency from `start` to first word.
- With `m_tready` held at 1: one word per cycle, last word in cycle N_WORDS+2, `done` in cycle N_WORDS+3. For N_WORDS=6: words in cycles 3–8, `m_tlast` in cycle 8, `done` in cycle 9.
- Under backpressure, reads stall so that buffer plus in-flight never exceeds 2. Throughput recovers to 1 word/cycle on the cycle `m_tready` returns.
- N_WORDS=1: single beat with `m_tlast`=1 in cycle 3.
- `done` falls on the cycle after `start` is sampled low. The next `start` may begin a new packet from the following cycle.

## Structure
- Shared package `result_streamer_pkg`:
  - state enum (IDLE, RUN, FLUSH, DONE)
  - `WORD_BYTES`=4
- One sub-module, `stream_fifo2`: 2-entry synchronous FIFO with registered outputs and push/pop/occupancy. Simultaneous push and pop when full is legal.
- Top level holds the FSM, counters and credit logic.

## Test plan
- Reset, then `start`=1 with `m_tready`=1 and BRAM preloaded 0x3F800000+i for i=0..5 → words 0x3F800000..0x3F800005 in cycles 3–8, `m_tlast` only in cycle 8, `done`=1 in cycle 9.
- `m_tready` randomized at 30% → same 6 words in order, no drop or duplicate, `m_tdata` stable while stalled, `rd_en` never leaves buffer+inflight above 2.
- `m_tready`=0 for 20 cycles from cycle 3 → exactly 2 reads issued, `m_tvalid` held with word 0. On release, the remaining words stream at 1/cycle.
- `start` held high after `done` → `done` stays 1 and no new reads occur. `start` low then high → a second packet starts again from `BASE_ADDR`.
- `reset` asserted while word 3 is stalled → next cycle all outputs are at reset values. A fresh `start` gives a full 6-word packet from word 0.
- `N_WORDS`=1, `BASE_ADDR`=0x40 → single read at address 0x40, one beat with `m_tlast`=1, `done` in cycle 4.
